// File: rtl/usb_pkg.sv
// Shared USB transmit definitions: PID codes, framing constants, CRC16
// parameters and the packet sequencer state encoding.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  localparam logic [7:0]  SYNC_BYTE       = 8'h80;
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_CRC_LO,
    ST_CRC_HI,
    ST_DONE
  } state_t;

endpackage

// File: rtl/usb_crc16.sv
// Byte-wide USB CRC16 update (reflected polynomial, LSB-first), purely
// combinational so the sequencer can fold one payload byte per accept.
module usb_crc16
  import usb_pkg::*;
(
  input  logic [15:0] crc,
  input  logic [7:0]  data,
  output logic [15:0] next_crc
);

  logic [15:0] c;

  always_comb begin
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC16_POLY_REFL) : (c >> 1);
    end
    next_crc = c;
  end

endmodule

// File: rtl/usb_tx_packet_ctrl.sv
// USB transmit packet sequencer: SYNC, PID, FIFO payload and CRC16 onto a
// byte-wide valid/ready serializer link.
module usb_tx_packet_ctrl
  import usb_pkg::*;
#(
  parameter int MAX_PAYLOAD = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [3:0] tx_pid,
  input  logic       tx_has_data,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_read_data,
  output logic       fifo_read_enable,
  output logic [7:0] ser_byte,
  output logic       ser_valid,
  input  logic       ser_ready,
  output logic       ser_eop,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CNT_W = $clog2(MAX_PAYLOAD + 1);

  state_t           state, state_next;
  logic [3:0]       pid;
  logic             has_data;
  logic [CNT_W-1:0] count;
  logic [15:0]      crc, crc_next, crc_out;
  logic             payload_end;

  assign payload_end = fifo_empty || (count == CNT_W'(MAX_PAYLOAD));
  assign crc_out     = ~crc;

  usb_crc16 u_crc (
    .crc      (crc),
    .data     (fifo_read_data),
    .next_crc (crc_next)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Packet context is only read after a start has been accepted, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && tx_start) begin
      pid      <= tx_pid;
      has_data <= tx_has_data;
      count    <= '0;
      crc      <= CRC16_INIT;
    end else if (fifo_read_enable) begin
      count <= count + CNT_W'(1);
      crc   <= crc_next;
    end
  end

  always_comb begin
    state_next       = state;
    ser_byte         = 8'h00;
    ser_valid        = 1'b0;
    ser_eop          = 1'b0;
    fifo_read_enable = 1'b0;
    tx_busy          = 1'b1;
    tx_done          = 1'b0;
    unique case (state)
      ST_IDLE: begin
        tx_busy = 1'b0;
        if (tx_start) state_next = ST_SYNC;
      end
      ST_SYNC: begin
        ser_byte  = SYNC_BYTE;
        ser_valid = 1'b1;
        if (ser_ready) state_next = ST_PID;
      end
      ST_PID: begin
        ser_byte  = {~pid, pid};
        ser_valid = 1'b1;
        ser_eop   = !has_data;
        if (ser_ready) state_next = has_data ? ST_DATA : ST_DONE;
      end
      ST_DATA: begin
        // The FIFO head stays put until popped, so a stalled byte is held stable.
        if (payload_end) begin
          state_next = ST_CRC_LO;
        end else begin
          ser_byte  = fifo_read_data;
          ser_valid = 1'b1;
          if (ser_ready) fifo_read_enable = 1'b1;
        end
      end
      ST_CRC_LO: begin
        ser_byte  = crc_out[7:0];
        ser_valid = 1'b1;
        if (ser_ready) state_next = ST_CRC_HI;
      end
      ST_CRC_HI: begin
        ser_byte  = crc_out[15:8];
        ser_valid = 1'b1;
        ser_eop   = 1'b1;
        if (ser_ready) state_next = ST_DONE;
      end
      ST_DONE: begin
        tx_done    = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_usb_tx_packet_ctrl.sv
// Bench for usb_tx_packet_ctrl: FIFO and serializer models, a packet-level
// reference that predicts every accepted byte, plus literal packet checks.
module tb_usb_tx_packet_ctrl;
  import usb_pkg::*;

  localparam int MAXP = 9;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       tx_start = 1'b0;
  logic [3:0] tx_pid = 4'h0;
  logic       tx_has_data = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_read_data = 8'h00;
  logic       ser_ready = 1'b0;
  logic       fifo_read_enable, ser_valid, ser_eop, tx_busy, tx_done;
  logic [7:0] ser_byte;

  int errors = 0;
  int checks = 0;
  int pops = 0;

  byte unsigned fifo_q[$];
  byte unsigned acc_log[$];
  byte unsigned lit[$];
  byte unsigned saved[$];
  logic [8:0]   exp_q[$];

  bit         idle_m = 1'b1;
  bit         done_due = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  logic       prev_eop = 1'b0;
  bit         rdy_random = 1'b0;
  bit         start_ok, acc;
  logic [8:0] e;

  always #5 clk = ~clk;

  usb_tx_packet_ctrl #(.MAX_PAYLOAD(MAXP)) dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .tx_start         (tx_start),
    .tx_pid           (tx_pid),
    .tx_has_data      (tx_has_data),
    .fifo_empty       (fifo_empty),
    .fifo_read_data   (fifo_read_data),
    .fifo_read_enable (fifo_read_enable),
    .ser_byte         (ser_byte),
    .ser_valid        (ser_valid),
    .ser_ready        (ser_ready),
    .ser_eop          (ser_eop),
    .tx_busy          (tx_busy),
    .tx_done          (tx_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic fifo_sync();
    fifo_empty     = (fifo_q.size() == 0);
    fifo_read_data = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  // Whole-message USB CRC16, bit-serial, returned already complemented.
  function automatic logic [15:0] crc_usb(input byte unsigned msg[$], input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ msg[i][j];
        c  = {1'b0, c[15:1]};
        if (fb) c = c ^ 16'hA001;
      end
    return ~c;
  endfunction

  task automatic build(input logic [3:0] p, input logic hd);
    int n;
    logic [15:0] c;
    exp_q.delete();
    exp_q.push_back({1'b0, 8'h80});
    exp_q.push_back({1'b0, ~p, p});
    if (hd) begin
      n = (fifo_q.size() < MAXP) ? fifo_q.size() : MAXP;
      for (int i = 0; i < n; i++) exp_q.push_back({1'b1, fifo_q[i]});
      c = crc_usb(fifo_q, n);
      exp_q.push_back({1'b0, c[7:0]});
      exp_q.push_back({1'b0, c[15:8]});
    end
  endtask

  // FIFO model: pop decided at the falling edge, applied just after the rising edge.
  initial begin
    bit pend;
    forever begin
      @(negedge clk);
      pend = fifo_read_enable;
      @(posedge clk);
      #1;
      if (pend && fifo_q.size() > 0) begin
        fifo_q.delete(0);
        pops++;
        fifo_sync();
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      ser_ready = rdy_random ? ($urandom_range(0, 99) < 60) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!n_rst) begin
      chk("rst_valid", 32'(ser_valid), 32'(0));
      chk("rst_rd_en", 32'(fifo_read_enable), 32'(0));
      chk("rst_byte", 32'(ser_byte), 32'(0));
      chk("rst_eop", 32'(ser_eop), 32'(0));
      chk("rst_busy", 32'(tx_busy), 32'(0));
      chk("rst_done", 32'(tx_done), 32'(0));
      exp_q.delete();
      idle_m = 1'b1;
      done_due = 1'b0;
      prev_stall = 1'b0;
    end else begin
      start_ok = tx_start && idle_m;
      chk("busy", 32'(tx_busy), 32'(!idle_m));
      chk("done", 32'(tx_done), 32'(done_due));
      if (done_due) begin
        done_due = 1'b0;
        idle_m = 1'b1;
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(ser_valid), 32'(1));
        chk("stall_byte", 32'(ser_byte), 32'(prev_byte));
        chk("stall_eop", 32'(ser_eop), 32'(prev_eop));
      end
      acc = ser_valid && ser_ready;
      if (acc) begin
        if (exp_q.size() == 0) begin
          chk("extra_byte_valid", 32'(ser_valid), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("byte", 32'(ser_byte), 32'(e[7:0]));
          chk("eop", 32'(ser_eop), 32'(exp_q.size() == 0));
          chk("pop", 32'(fifo_read_enable), 32'(e[8]));
          acc_log.push_back(ser_byte);
          if (exp_q.size() == 0) done_due = 1'b1;
        end
      end else begin
        chk("pop_no_accept", 32'(fifo_read_enable), 32'(0));
      end
      chk("pop_on_empty", 32'(fifo_read_enable && fifo_empty), 32'(0));
      prev_stall = ser_valid && !ser_ready;
      prev_byte  = ser_byte;
      prev_eop   = ser_eop;
      if (start_ok) begin
        build(tx_pid, tx_has_data);
        idle_m = 1'b0;
      end
    end
  end

  task automatic start_pkt(input logic [3:0] p, input logic hd);
    #1;
    tx_start    = 1'b1;
    tx_pid      = p;
    tx_has_data = hd;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (k < budget) begin
      @(negedge clk);
      if (tx_done) break;
      k++;
    end
    if (k >= budget) chk("done_timeout", 32'(tx_done), 32'(1));
    @(posedge clk);
  endtask

  task automatic chk_log(input string name);
    chk({name, "_len"}, 32'(acc_log.size()), 32'(lit.size()));
    for (int i = 0; i < lit.size() && i < acc_log.size(); i++)
      chk(name, 32'(acc_log[i]), 32'(lit[i]));
  endtask

  initial begin
    int p0, nb, k;
    fifo_sync();
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    @(posedge clk);

    // ACK handshake, FIFO contents must be left alone
    fifo_q = '{8'h11, 8'h22, 8'h33};
    fifo_sync();
    acc_log.delete();
    p0 = pops;
    start_pkt(PID_ACK, 1'b0);
    wait_done(50);
    lit = '{8'h80, 8'hD2};
    chk_log("ack_bytes");
    chk("ack_pops", 32'(pops - p0), 32'(0));
    chk("ack_fifo_left", 32'(fifo_q.size()), 32'(3));
    fifo_q.delete();
    fifo_sync();

    // "123456789" payload: CRC16/USB check value 0xB4C8
    for (int i = 0; i < 9; i++) fifo_q.push_back(8'(8'h31 + i));
    fifo_sync();
    acc_log.delete();
    p0 = pops;
    start_pkt(PID_DATA0, 1'b1);
    wait_done(100);
    lit = '{8'h80, 8'hC3, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};
    chk_log("data0_bytes");
    chk("data0_pops", 32'(pops - p0), 32'(9));

    // zero-length data packet
    acc_log.delete();
    start_pkt(PID_DATA1, 1'b1);
    wait_done(50);
    lit = '{8'h80, 8'h4B, 8'h00, 8'h00};
    chk_log("zlp_bytes");

    // payload limit: 11 queued, MAXP sent, remainder goes in the next packet
    for (int i = 0; i < 11; i++) fifo_q.push_back(8'(8'hA0 + i));
    fifo_sync();
    acc_log.delete();
    start_pkt(PID_DATA0, 1'b1);
    wait_done(100);
    chk("limit_len", 32'(acc_log.size()), 32'(MAXP + 4));
    chk("limit_fifo_left", 32'(fifo_q.size()), 32'(2));
    acc_log.delete();
    start_pkt(PID_DATA1, 1'b1);
    wait_done(100);
    chk("limit_rest_len", 32'(acc_log.size()), 32'(6));
    if (acc_log.size() >= 4) begin
      chk("limit_rest_b0", 32'(acc_log[2]), 32'(8'hA9));
      chk("limit_rest_b1", 32'(acc_log[3]), 32'(8'hAA));
    end

    // random packets with serializer stalls and ignored starts while busy
    rdy_random = 1'b1;
    for (int p = 0; p < 25; p++) begin
      nb = $urandom_range(0, 12);
      if (fifo_q.size() > 20) fifo_q.delete();
      for (int i = 0; i < nb; i++) fifo_q.push_back(8'($urandom));
      fifo_sync();
      start_pkt(4'($urandom), 1'($urandom_range(0, 3) != 0));
      if (p % 3 == 0) begin
        tx_start = 1'b1;
        tx_pid   = 4'($urandom);
        @(posedge clk);
        #1;
        tx_start = 1'b0;
      end
      wait_done(400);
    end
    rdy_random = 1'b0;

    // reset after two payload bytes accepted
    fifo_q.delete();
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'(8'h50 + i));
    saved = fifo_q;
    fifo_sync();
    p0 = pops;
    start_pkt(PID_DATA0, 1'b1);
    k = 0;
    while (pops != p0 + 2 && k < 200) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk("rst_wait_pops", 32'(pops - p0), 32'(2));
    n_rst = 1'b0;
    #1;
    chk("rst_now_valid", 32'(ser_valid), 32'(0));
    chk("rst_now_busy", 32'(tx_busy), 32'(0));
    chk("rst_now_rd_en", 32'(fifo_read_enable), 32'(0));
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (5) @(posedge clk);
    chk("rst_fifo_left", 32'(fifo_q.size()), 32'(4));
    acc_log.delete();
    start_pkt(PID_DATA1, 1'b1);
    wait_done(100);
    chk("rst_resume_len", 32'(acc_log.size()), 32'(8));
    if (acc_log.size() >= 3) chk("rst_resume_b0", 32'(acc_log[2]), 32'(saved[2]));

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
